ex_unit: RTL
============

EX_UNIT -- requirements
Module: ex_unit

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: pc_in, instruction_in, btarget_in, A_in, B_in, op2_in  input  32 each  operand-fetch pipeline register contents.
REQ-004 SHALL have ports: control_bus_in  input  24  decoded controls; valid_in  input  1  instruction present.
REQ-005 SHALL have ports: stall  output  1  upstream must hold all inputs unchanged while high.
REQ-006 SHALL have ports: branch_taken  output  1; branch_pc  output  32  redirect to fetch.
REQ-007 SHALL have ports: pc_out, instruction_out, alu_result_out, op2_out  output  32 each; control_bus_out  output  24; valid_out  output  1  execute/memory pipeline register.

Function
REQ-008 SHALL decode the ALU operation from instruction_in[31:27]: 0 add, 1 sub, 2 mul, 3 div, 4 mod, 5 cmp, 6 and, 7 or, 8 not, 9 mov, 10 lsl, 11 lsr, 12 asr; all other codes produce result 0.
REQ-009 SHALL compute single-cycle ops on A_in (first operand) and B_in (second operand), 32-bit wrap-around; mul keeps the low 32 bits of the signed product; not/mov use B_in only; shift amount is B_in[4:0].
REQ-010 SHALL compute div/mod as signed two's-complement values using a 32-iteration sequential divider: quotient truncates toward zero; remainder takes the sign of the dividend.
REQ-011 SHALL handle divide by zero by producing quotient 0xFFFFFFFF and remainder = A_in, with latency equal to the normal divide latency.
REQ-012 SHALL implement divider FSM IDLE -> BUSY -> DONE -> IDLE.
REQ-013 SHALL transition IDLE -> BUSY when valid_in=1 and the op is div or mod, loading the iteration counter with 32.
REQ-014 SHALL, in BUSY, decrement the iteration counter once per cycle and transition BUSY -> DONE when it reaches 0.
REQ-015 SHALL, in DONE, present the quotient or remainder as the result, then transition to IDLE.
REQ-016 SHALL drive stall=1 in the IDLE cycle that accepts a div/mod and in every BUSY cycle (33 cycles total); stall=0 in DONE and in IDLE for all other ops.
REQ-017 SHALL keep a flags register {E, GT}; a valid cmp that is not stalled sets E=(A_in==B_in) and GT=(signed A_in > signed B_in); the flags are otherwise held.
REQ-018 SHALL compute branch_taken = valid_in & ~stall & (control_bus_in[17] | (control_bus_in[15] & E) | (control_bus_in[16] & GT)), where bit 15 is isBeq, bit 16 is isBgt, and bit 17 is the unconditional branch (b/call).
REQ-019 SHALL treat isRet (control_bus_in[19]) as a taken branch with branch_pc = A_in; otherwise branch_pc = btarget_in; both outputs are combinational.
REQ-020 SHALL use the flags as registered before the current edge (a cmp immediately followed by beq sees the updated flags, because the cmp commits one edge earlier).
REQ-021 SHALL load the execute/memory register on each edge where stall=0, taking pc, instruction, control_bus, op2, the result and valid_in.
REQ-022 SHALL, on each edge where stall=1, load the execute/memory register with a bubble: valid_out=0 and all other outputs 0.
REQ-023 SHALL give single-cycle ops a latency of 1 edge; a div/mod SHALL appear on valid_out 34 edges after first presentation.

Reset
REQ-024 SHALL, while reset=0 and asynchronously, clear all outputs and registers to 0, set flags E=GT=0, set FSM to IDLE and the iteration counter to 0.
REQ-025 SHALL abort a division in progress on reset; after release the FSM restarts from IDLE and the aborted instruction is not completed.

Verification
REQ-026 SHALL cover: add with A=5, B=7, valid_in=1 -> after 1 edge alu_result_out=12, valid_out=1, stall=0 throughout.
REQ-027 SHALL cover: cmp 3,3 followed by beq with btarget_in=0x40 -> branch_taken=1, branch_pc=0x40; repeating with cmp 3,4 -> branch_taken=0.
REQ-028 SHALL cover: div with A=-20, B=6 -> stall high for 33 cycles, then after edge 34 alu_result_out=0xFFFFFFFD (-3), valid_out=1; mod with the same operands -> 0xFFFFFFFE (-2).
REQ-029 SHALL cover: div with A=9, B=0 -> alu_result_out=0xFFFFFFFF with the same latency; mod with A=9, B=0 -> 9.
REQ-030 SHALL cover: reset=0 asserted at BUSY cycle 10 -> stall=0 and valid_out=0 immediately; a subsequent add completes in 1 edge.
REQ-031 SHALL cover: ret with A_in=0x1234 -> branch_taken=1, branch_pc=0x1234; a valid beq during a stalled div -> branch_taken=0.

Source files
------------

// File: rtl/ex_unit.sv
// Execute stage: single-cycle ALU, 32-iteration signed sequential divider,
// compare flags, branch resolution and the execute/memory pipeline register.
module ex_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_in,
    input  logic [31:0] instruction_in,
    input  logic [31:0] btarget_in,
    input  logic [31:0] A_in,
    input  logic [31:0] B_in,
    input  logic [31:0] op2_in,
    input  logic [23:0] control_bus_in,
    input  logic        valid_in,
    output logic        stall,
    output logic        branch_taken,
    output logic [31:0] branch_pc,
    output logic [31:0] pc_out,
    output logic [31:0] instruction_out,
    output logic [31:0] alu_result_out,
    output logic [31:0] op2_out,
    output logic [23:0] control_bus_out,
    output logic        valid_out
);

    typedef enum logic [4:0] {
        OP_ADD = 5'd0,  OP_SUB = 5'd1,  OP_MUL = 5'd2,  OP_DIV = 5'd3,
        OP_MOD = 5'd4,  OP_CMP = 5'd5,  OP_AND = 5'd6,  OP_OR  = 5'd7,
        OP_NOT = 5'd8,  OP_MOV = 5'd9,  OP_LSL = 5'd10, OP_LSR = 5'd11,
        OP_ASR = 5'd12
    } alu_op_t;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;

    div_state_t  state;
    logic [5:0]  cnt;
    logic [31:0] rem, quo, dsr;
    logic        neg_q, neg_r;
    logic        flag_e, flag_gt;

    logic [4:0]  op;
    logic        is_divmod, accept;
    logic [31:0] alu_res, div_res, rem_sh, q_fix, r_fix;
    logic        fits;

    assign op        = instruction_in[31:27];
    assign is_divmod = (op == OP_DIV) || (op == OP_MOD);
    assign accept    = (state == IDLE) && valid_in && is_divmod;
    assign stall     = accept || (state == BUSY);

    // One restoring step: quotient bits shift into quo as dividend bits leave it
    assign rem_sh = {rem[30:0], quo[31]};
    assign fits   = (rem_sh >= dsr);
    assign q_fix  = neg_q ? (~quo + 32'd1) : quo;
    assign r_fix  = neg_r ? (~rem + 32'd1) : rem;

    always_comb begin
        div_res = '0;
        if (B_in == 32'd0)
            div_res = (op == OP_DIV) ? 32'hFFFF_FFFF : A_in;
        else
            div_res = (op == OP_DIV) ? q_fix : r_fix;
    end

    always_comb begin
        alu_res = '0;
        case (op)
            OP_ADD:  alu_res = A_in + B_in;
            OP_SUB:  alu_res = A_in - B_in;
            OP_MUL:  alu_res = $signed(A_in) * $signed(B_in);
            OP_DIV,
            OP_MOD:  alu_res = (state == DONE) ? div_res : 32'd0;
            OP_CMP:  alu_res = A_in - B_in;
            OP_AND:  alu_res = A_in & B_in;
            OP_OR:   alu_res = A_in | B_in;
            OP_NOT:  alu_res = ~B_in;
            OP_MOV:  alu_res = B_in;
            OP_LSL:  alu_res = A_in << B_in[4:0];
            OP_LSR:  alu_res = A_in >> B_in[4:0];
            OP_ASR:  alu_res = $signed(A_in) >>> B_in[4:0];
            default: alu_res = '0;
        endcase
    end

    // isRet (bit 19) redirects to the return address held in A_in
    assign branch_taken = valid_in & ~stall &
                          (control_bus_in[17] | control_bus_in[19] |
                           (control_bus_in[15] & flag_e) | (control_bus_in[16] & flag_gt));
    assign branch_pc    = control_bus_in[19] ? A_in : btarget_in;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            rem   <= '0;
            quo   <= '0;
            dsr   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    state <= BUSY;
                    cnt   <= 6'd32;
                    rem   <= '0;
                    quo   <= A_in[31] ? (~A_in + 32'd1) : A_in;
                    dsr   <= B_in[31] ? (~B_in + 32'd1) : B_in;
                    neg_q <= A_in[31] ^ B_in[31];
                    neg_r <= A_in[31];
                end
                BUSY: begin
                    cnt <= cnt - 6'd1;
                    rem <= fits ? (rem_sh - dsr) : rem_sh;
                    quo <= {quo[30:0], fits};
                    if (cnt == 6'd1) state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flag_e  <= 1'b0;
            flag_gt <= 1'b0;
        end else if (valid_in && !stall && op == OP_CMP) begin
            flag_e  <= (A_in == B_in);
            flag_gt <= ($signed(A_in) > $signed(B_in));
        end
    end

    // Stalled edges push a bubble so the div/mod never double-issues downstream
    always_ff @(posedge clk or negedge reset) begin
        if (!reset || stall) begin
            if (!reset) begin
                pc_out <= '0; instruction_out <= '0; alu_result_out <= '0;
                op2_out <= '0; control_bus_out <= '0; valid_out <= 1'b0;
            end else begin
                pc_out <= '0; instruction_out <= '0; alu_result_out <= '0;
                op2_out <= '0; control_bus_out <= '0; valid_out <= 1'b0;
            end
        end else begin
            pc_out          <= pc_in;
            instruction_out <= instruction_in;
            alu_result_out  <= alu_res;
            op2_out         <= op2_in;
            control_bus_out <= control_bus_in;
            valid_out       <= valid_in;
        end
    end

endmodule
